// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling with framing-error detect.
// Ports: i_CLK, i_RST (sync, active-high), i_SERIAL in; o_DV, o_BYTE, o_FERR, o_BUSY out.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_SERIAL,
    output logic       o_DV,
    output logic [7:0] o_BYTE,
    output logic       o_FERR,
    output logic       o_BUSY
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [13:0] HALF_M1 = 14'(HALF_BIT - 1);
    localparam logic [13:0] BIT_M1  = 14'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        s_IDLE  = 3'd0,
        s_START = 3'd1,
        s_DATA  = 3'd2,
        s_STOP  = 3'd3,
        s_BREAK = 3'd4
    } state_t;

    state_t      r_STATE;
    logic        r_RX_META;
    logic        r_RX;
    logic [13:0] r_CNT;
    logic [2:0]  r_IDX;
    logic [7:0]  r_SHIFT;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_STATE   <= s_IDLE;
            r_RX_META <= 1'b1;
            r_RX      <= 1'b1;
            r_CNT     <= '0;
            r_IDX     <= '0;
            r_SHIFT   <= '0;
            o_BYTE    <= '0;
            o_DV      <= 1'b0;
            o_FERR    <= 1'b0;
            o_BUSY    <= 1'b0;
        end else begin
            r_RX_META <= i_SERIAL;
            r_RX      <= r_RX_META;
            o_DV      <= 1'b0;
            o_FERR    <= 1'b0;

            case (r_STATE)
                s_IDLE: begin
                    r_CNT <= '0;
                    r_IDX <= '0;
                    if (!r_RX) begin
                        r_STATE <= s_START;
                        o_BUSY  <= 1'b1;
                    end else begin
                        o_BUSY  <= 1'b0;
                    end
                end

                // Re-check the line at the middle of the start bit so short
                // glitches never start a frame.
                s_START: begin
                    if (r_CNT == HALF_M1) begin
                        r_CNT <= '0;
                        if (!r_RX) begin
                            r_STATE <= s_DATA;
                        end else begin
                            r_STATE <= s_IDLE;
                            o_BUSY  <= 1'b0;
                        end
                    end else begin
                        r_CNT <= r_CNT + 14'd1;
                    end
                end

                s_DATA: begin
                    if (r_CNT == BIT_M1) begin
                        r_CNT          <= '0;
                        r_SHIFT[r_IDX] <= r_RX;
                        if (r_IDX == 3'd7) begin
                            r_IDX   <= '0;
                            r_STATE <= s_STOP;
                        end else begin
                            r_IDX   <= r_IDX + 3'd1;
                        end
                    end else begin
                        r_CNT <= r_CNT + 14'd1;
                    end
                end

                // Leaving at mid stop bit gives half a bit of slack for the
                // next start edge in back-to-back traffic.
                s_STOP: begin
                    if (r_CNT == BIT_M1) begin
                        r_CNT <= '0;
                        if (r_RX) begin
                            o_BYTE  <= r_SHIFT;
                            o_DV    <= 1'b1;
                            r_STATE <= s_IDLE;
                            o_BUSY  <= 1'b0;
                        end else begin
                            o_FERR  <= 1'b1;
                            r_STATE <= s_BREAK;
                        end
                    end else begin
                        r_CNT <= r_CNT + 14'd1;
                    end
                end

                // Wait out a held-low line so it cannot look like a new start.
                s_BREAK: begin
                    r_CNT <= '0;
                    r_IDX <= '0;
                    if (r_RX) begin
                        r_STATE <= s_IDLE;
                        o_BUSY  <= 1'b0;
                    end
                end

                default: begin
                    r_STATE <= s_IDLE;
                    r_CNT   <= '0;
                    r_IDX   <= '0;
                    o_BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: small-divider instance for protocol cases,
// full-rate instance (CLKS_PER_BIT=10416) run in parallel for one frame.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int CPB_B = 10416;

    logic       clk;
    logic       rst;
    logic       ser;
    logic       dv;
    logic [7:0] byte_o;
    logic       ferr;
    logic       busy;

    logic       rst_b;
    logic       ser_b;
    logic       dv_b;
    logic [7:0] byte_b;
    logic       ferr_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int dv_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int dv_cyc = 0;
    logic [7:0] dv_log[$];

    int dv_b_cnt = 0;
    int ferr_b_cnt = 0;
    int dv_b_cyc = 0;
    int busy_b_rise = 0;
    logic busy_b_prev = 1'b0;
    logic [7:0] byte_b_got = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_SERIAL(ser),
        .o_DV    (dv),
        .o_BYTE  (byte_o),
        .o_FERR  (ferr),
        .o_BUSY  (busy)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .i_CLK   (clk),
        .i_RST   (rst_b),
        .i_SERIAL(ser_b),
        .o_DV    (dv_b),
        .o_BYTE  (byte_b),
        .o_FERR  (ferr_b),
        .o_BUSY  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
            dv_log.push_back(byte_o);
        end
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (dv && ferr) both_cnt <= both_cnt + 1;
        if (dv_b) begin
            dv_b_cnt   <= dv_b_cnt + 1;
            dv_b_cyc   <= cyc;
            byte_b_got <= byte_b;
        end
        if (ferr_b) ferr_b_cnt <= ferr_b_cnt + 1;
        if (busy_b && !busy_b_prev) busy_b_rise <= cyc;
        busy_b_prev <= busy_b;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_s(input logic b);
        ser = b;
        cw(CPB);
    endtask

    // Caller is at posedge+1; returns at posedge+1 right after the stop bit.
    task automatic send(input logic [7:0] d, input logic stop,
                        output int t0);
        t0 = cyc;
        bit_s(1'b0);
        for (int i = 0; i < 8; i++) bit_s(d[i]);
        bit_s(stop);
        ser = 1'b1;
    endtask

    task automatic small_tests;
        int t0;
        int lat;
        int n_dv;
        int n_fe;

        chk("rst_dv",   32'(dv),     0);
        chk("rst_ferr", 32'(ferr),   0);
        chk("rst_busy", 32'(busy),   0);
        chk("rst_byte", 32'(byte_o), 0);
        rst = 1'b0;
        cw(1);

        // 0xA5 frame, latency from start edge
        n_dv = dv_cnt;
        n_fe = ferr_cnt;
        send(8'hA5, 1'b1, t0);
        cw(2);
        lat = dv_cyc - t0;
        chk("a5_dv_cnt", 32'(dv_cnt - n_dv), 1);
        chk("a5_ferr",   32'(ferr_cnt - n_fe), 0);
        chk("a5_byte",   32'(byte_o), 32'hA5);
        chk($sformatf("a5_lat_%0d_in_153_155", lat),
            32'(lat >= 153 && lat <= 155), 1);
        cw(20);

        // 3-cycle glitch
        n_dv = dv_cnt;
        n_fe = ferr_cnt;
        ser = 1'b0;
        cw(3);
        ser = 1'b1;
        chk("glitch_busy_rise", 32'(busy), 1);
        for (int k = 0; k < 11; k++) begin
            if (busy) cw(1);
        end
        chk("glitch_busy_fall", 32'(busy), 0);
        cw(20);
        chk("glitch_dv",   32'(dv_cnt - n_dv), 0);
        chk("glitch_ferr", 32'(ferr_cnt - n_fe), 0);

        // framing error then held-low line
        n_dv = dv_cnt;
        n_fe = ferr_cnt;
        send(8'h3C, 1'b0, t0);
        ser = 1'b0;
        cw(40);
        chk("fe_ferr_cnt", 32'(ferr_cnt - n_fe), 1);
        chk("fe_dv_cnt",   32'(dv_cnt - n_dv), 0);
        chk("fe_byte",     32'(byte_o), 32'hA5);
        chk("fe_busy_low", 32'(busy), 1);
        ser = 1'b1;
        cw(4);
        chk("fe_busy_idle", 32'(busy), 0);
        cw(10);
        send(8'h55, 1'b1, t0);
        cw(2);
        chk("fe_next_dv",   32'(dv_cnt - n_dv), 1);
        chk("fe_next_byte", 32'(byte_o), 32'h55);
        chk("fe_next_ferr", 32'(ferr_cnt - n_fe), 1);
        cw(20);

        // back-to-back 0x00, 0xFF
        n_dv = dv_cnt;
        n_fe = ferr_cnt;
        send(8'h00, 1'b1, t0);
        send(8'hFF, 1'b1, t0);
        cw(4);
        chk("b2b_dv_cnt", 32'(dv_cnt - n_dv), 2);
        chk("b2b_ferr",   32'(ferr_cnt - n_fe), 0);
        if (dv_cnt - n_dv == 2) begin
            chk("b2b_byte0", 32'(dv_log[n_dv]),     32'h00);
            chk("b2b_byte1", 32'(dv_log[n_dv + 1]), 32'hFF);
        end
        cw(20);

        // reset during data bit 3
        n_dv = dv_cnt;
        n_fe = ferr_cnt;
        fork
            send(8'hFF, 1'b1, t0);
            begin
                cw(CPB + 3 * CPB + CPB / 2);
                rst = 1'b1;
                cw(1);
                rst = 1'b0;
                chk("mid_rst_dv",   32'(dv),     0);
                chk("mid_rst_ferr", 32'(ferr),   0);
                chk("mid_rst_busy", 32'(busy),   0);
                chk("mid_rst_byte", 32'(byte_o), 0);
            end
        join
        cw(40);
        chk("abort_dv",   32'(dv_cnt - n_dv), 0);
        chk("abort_ferr", 32'(ferr_cnt - n_fe), 0);
        send(8'h81, 1'b1, t0);
        cw(2);
        chk("post_rst_dv",   32'(dv_cnt - n_dv), 1);
        chk("post_rst_byte", 32'(byte_o), 32'h81);
        chk("dv_ferr_excl",  32'(both_cnt), 0);
    endtask

    // Full-rate frame; stops as soon as the mid-stop sample has been taken.
    task automatic big_test;
        int t0;
        int lat;
        logic [7:0] d;
        d = 8'h7E;
        rst_b = 1'b0;
        cw(1);
        t0 = cyc;
        ser_b = 1'b0;
        cw(CPB_B);
        for (int i = 0; i < 8; i++) begin
            ser_b = d[i];
            cw(CPB_B);
        end
        ser_b = 1'b1;
        for (int k = 0; k < 2 * CPB_B; k++) begin
            if (dv_b_cnt == 0) cw(1);
        end
        cw(2);
        lat = dv_b_cyc - t0;
        chk("big_dv_cnt", 32'(dv_b_cnt), 1);
        chk("big_ferr",   32'(ferr_b_cnt), 0);
        chk("big_byte",   32'(byte_b_got), 32'h7E);
        chk("big_sample_span", 32'(dv_b_cyc - busy_b_rise),
            32'(CPB_B / 2 + 9 * CPB_B));
        chk($sformatf("big_lat_%0d_in_98953_98955", lat),
            32'(lat >= 98953 && lat <= 98955), 1);
    endtask

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        ser   = 1'b1;
        ser_b = 1'b1;
        cw(3);
        fork
            small_tests();
            big_test();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
